// File: rtl/ts_buffer_occupancy_tracker.sv
// Per-flow TS packet occupancy counters for the host injection buffer.
// Publishes a registered full/disabled vector and counts enqueue and release errors.
module ts_buffer_occupancy_tracker #(
    parameter int                FLOW_NUM      = 32,
    parameter int                CNT_W         = 8,
    parameter logic [CNT_W-1:0]  DEFAULT_LIMIT = 8'd4,
    localparam int               FID_W         = $clog2(FLOW_NUM)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ts_enq,
    input  logic [FID_W-1:0]     iv_ts_enq_flowid,
    input  logic                 i_ts_deq,
    input  logic [FID_W-1:0]     iv_ts_deq_flowid,
    input  logic                 i_cfg_wr,
    input  logic [FID_W-1:0]     iv_cfg_addr,
    input  logic [CNT_W-1:0]     iv_cfg_limit,
    input  logic                 i_cfg_clr,
    output logic [FLOW_NUM-1:0]  ov_ts_cnt,
    output logic                 o_init_done,
    output logic                 o_enq_err_pulse,
    output logic                 o_deq_err_pulse,
    output logic [15:0]          ov_err_cnt
);

    typedef enum logic {INIT_S, RUN_S} state_t;

    state_t                  state;
    logic [FID_W-1:0]        init_idx;
    logic [CNT_W-1:0]        cnt     [FLOW_NUM];
    logic [CNT_W-1:0]        lim     [FLOW_NUM];
    logic [CNT_W-1:0]        cnt_nxt [FLOW_NUM];
    logic [FLOW_NUM-1:0]     ov_nxt;
    logic [FLOW_NUM-1:0]     enq_hit;
    logic [FLOW_NUM-1:0]     deq_hit;
    logic                    enq_err_nxt;
    logic                    deq_err_nxt;
    logic [16:0]             err_sum;

    assign enq_hit = i_ts_enq ? (FLOW_NUM'(1) << iv_ts_enq_flowid) : '0;
    assign deq_hit = i_ts_deq ? (FLOW_NUM'(1) << iv_ts_deq_flowid) : '0;

    // A simultaneous enqueue and release on one flow cancel out without error.
    always_comb begin
        enq_err_nxt = 1'b0;
        deq_err_nxt = 1'b0;
        ov_nxt      = '0;
        for (int f = 0; f < FLOW_NUM; f++) begin
            cnt_nxt[f] = cnt[f];
            if (enq_hit[f] && !deq_hit[f]) begin
                if (cnt[f] == '1) enq_err_nxt = 1'b1;
                else              cnt_nxt[f]  = cnt[f] + 1'b1;
            end else if (deq_hit[f] && !enq_hit[f]) begin
                if (cnt[f] == '0) deq_err_nxt = 1'b1;
                else              cnt_nxt[f]  = cnt[f] - 1'b1;
            end
            ov_nxt[f] = (lim[f] == '0) || (cnt_nxt[f] >= lim[f]);
        end
    end

    assign err_sum = {1'b0, ov_err_cnt} + 17'(enq_err_nxt) + 17'(deq_err_nxt);

    // Per-flow storage needs no reset: the init sweep rewrites every entry.
    always_ff @(posedge i_clk) begin
        if (state == INIT_S) begin
            cnt[init_idx] <= '0;
            lim[init_idx] <= DEFAULT_LIMIT;
        end else if (!i_cfg_clr) begin
            for (int f = 0; f < FLOW_NUM; f++) begin
                cnt[f] <= cnt_nxt[f];
            end
            if (i_cfg_wr) lim[iv_cfg_addr] <= iv_cfg_limit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= INIT_S;
            init_idx        <= '0;
            ov_ts_cnt       <= '1;
            o_init_done     <= 1'b0;
            o_enq_err_pulse <= 1'b0;
            o_deq_err_pulse <= 1'b0;
            ov_err_cnt      <= '0;
        end else if (i_cfg_clr) begin
            state           <= INIT_S;
            init_idx        <= '0;
            ov_ts_cnt       <= '1;
            o_init_done     <= 1'b0;
            o_enq_err_pulse <= 1'b0;
            o_deq_err_pulse <= 1'b0;
        end else if (state == INIT_S) begin
            o_enq_err_pulse <= 1'b0;
            o_deq_err_pulse <= 1'b0;
            if (init_idx == FID_W'(FLOW_NUM - 1)) begin
                // Every flow now holds count 0 against the default limit.
                state       <= RUN_S;
                init_idx    <= '0;
                o_init_done <= 1'b1;
                ov_ts_cnt   <= {FLOW_NUM{DEFAULT_LIMIT == '0}};
            end else begin
                init_idx    <= init_idx + 1'b1;
                ov_ts_cnt   <= '1;
            end
        end else begin
            ov_ts_cnt       <= ov_nxt;
            o_enq_err_pulse <= enq_err_nxt;
            o_deq_err_pulse <= deq_err_nxt;
            ov_err_cnt      <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule
